// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields into words.
// Range checks are built only when INSTR_ENC_RANGE_CHECK_EN is defined.
module instr_encoder #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_rem;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_done;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    logic              w_in_ready;
    logic              w_acc;
    logic              w_legal;
    logic              w_fmt_ok;
    logic [31:0]       w_word;
    logic              w_launch;
    logic              w_leave;

    assign w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_acc      = in_valid && w_in_ready;
    assign w_fmt_ok   = (fmt < 3'd6);
    assign w_launch   = (r_state == IDLE) && start && (count != '0);
    assign w_leave    = (r_state == DRAIN) && (!r_out_valid || out_ready);

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic w_fits12;
    logic w_fits20;
    logic w_u_ok;

    // Signed fit: all bits above the field's sign bit equal the sign bit.
    assign w_fits12 = (&imm[31:11]) || (~|imm[31:11]);
    assign w_fits20 = (&imm[31:19]) || (~|imm[31:19]);
    assign w_u_ok   = ~|imm[31:20];

    always_comb begin
        w_legal = 1'b0;
        unique case (fmt)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = w_fits12;
            3'd2:    w_legal = w_fits12;
            3'd3:    w_legal = w_fits12;
            3'd4:    w_legal = w_u_ok;
            3'd5:    w_legal = w_fits20;
            default: w_legal = 1'b0;
        endcase
    end
`else
    logic w_unused_imm;

    assign w_unused_imm = ^imm[31:20];
    assign w_legal      = w_fmt_ok;
`endif

    always_comb begin
        w_word = 32'd0;
        unique case (fmt)
            3'd0: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: w_word = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2: w_word = {imm[11:5], rs2, rs1, funct3,
                            imm[4:0], opcode};
            3'd3: w_word = {imm[11], imm[9:4], rs2, rs1, funct3,
                            imm[3:0], imm[10], opcode};
            3'd4: w_word = {imm[19:0], rd, opcode};
            3'd5: w_word = {imm[19], imm[9:0], imm[10],
                            imm[18:11], rd, opcode};
            default: w_word = 32'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_launch) w_next = RUN;
            RUN:     if (w_acc && (r_rem == 1)) w_next = DRAIN;
            DRAIN:   if (w_leave) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_done <= w_leave ||
                      ((r_state == IDLE) && start && (count == '0));
            r_err  <= w_acc && !w_legal;
            if (w_launch) begin
                r_ptr     <= {base[ADDR_W-1:2], 2'b00};
                r_rem     <= count;
                r_err_cnt <= 8'd0;
            end
            if (w_acc) begin
                r_rem <= r_rem - 1'b1;
                if (!w_legal && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_acc && w_legal) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_word;
                r_out_addr  <= r_ptr;
                r_ptr       <= r_ptr + ADDR_W'(4);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases plus random batches against
// a cycle model built from field arithmetic and simple counters.
module tb_instr_encoder;

    localparam int AW = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [CW-1:0] count = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    fmt = 3'd0;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic [6:0]    funct7 = 7'd0;
    logic [4:0]    rd = 5'd0;
    logic [4:0]    rs1 = 5'd0;
    logic [4:0]    rs2 = 5'd0;
    logic [31:0]   imm = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    err_count;

    instr_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base),
        .count(count), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .busy(busy),
        .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_act;
    int          m_left;
    int          m_ptr;
    bit          m_ov;
    logic [31:0] m_instr;
    int          m_addr;
    bit          m_done;
    bit          m_err;
    int          m_ec;

    int imm_edges[10] = '{2047, 2048, -2048, -2049, 524287,
                          524288, -524288, -524289,
                          32'h000FFFFF, 32'h00100000};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(
        input logic [2:0] f, input logic [31:0] op,
        input logic [31:0] f3, input logic [31:0] f7,
        input logic [31:0] d, input logic [31:0] s1,
        input logic [31:0] s2, input logic [31:0] v);
        logic [31:0] o;
        logic [31:0] w;
        o = v << 1;
        w = op + (d << 7);
        case (f)
            3'd0: w = w + (f3 << 12) + (s1 << 15) + (s2 << 20)
                      + (f7 << 25);
            3'd1: w = w + (f3 << 12) + (s1 << 15)
                      + ((v & 32'hFFF) << 20);
            3'd2: w = op + ((v & 31) << 7) + (f3 << 12)
                      + (s1 << 15) + (s2 << 20)
                      + (((v >> 5) & 127) << 25);
            3'd3: w = op + (((o >> 11) & 1) << 7)
                      + (((o >> 1) & 15) << 8) + (f3 << 12)
                      + (s1 << 15) + (s2 << 20)
                      + (((o >> 5) & 63) << 25)
                      + (((o >> 12) & 1) << 31);
            3'd4: w = w + ((v & 32'hFFFFF) << 12);
            3'd5: w = w + (((o >> 12) & 255) << 12)
                      + (((o >> 11) & 1) << 20)
                      + (((o >> 1) & 1023) << 21)
                      + (((o >> 20) & 1) << 31);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit legal(input logic [2:0] f,
                                 input logic [31:0] v);
        int s;
        s = v;
        if (f > 3'd5) return 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if (f == 3'd1 || f == 3'd2 || f == 3'd3)
            return (s >= -2048) && (s <= 2047);
        if (f == 3'd5)
            return (s >= -524288) && (s <= 524287);
        if (f == 3'd4)
            return v < 32'h00100000;
`endif
        return s == s;
    endfunction

    task automatic m_reset();
        m_act = 0; m_left = 0; m_ptr = 0; m_ov = 0;
        m_instr = 0; m_addr = 0; m_done = 0; m_err = 0; m_ec = 0;
    endtask

    task automatic cyc();
        bit acc, pre_act, pre_drain, pre_ov, rdy;
        #1;
        rdy = m_act && (m_left > 0) && (!m_ov || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        pre_act   = m_act;
        pre_drain = m_act && (m_left == 0);
        pre_ov    = m_ov;
        acc       = in_valid && rdy;
        m_done = 0;
        m_err  = 0;
        if (m_ov && out_ready) m_ov = 0;
        if (acc) begin
            m_left--;
            if (legal(fmt, imm)) begin
                m_ov    = 1;
                m_instr = enc(fmt, opcode, funct3, funct7,
                              rd, rs1, rs2, imm);
                m_addr  = m_ptr;
                m_ptr   = (m_ptr + 4) % 4096;
            end else begin
                m_err = 1;
                if (m_ec < 255) m_ec++;
            end
        end
        if (pre_drain && (!pre_ov || out_ready)) begin
            m_act  = 0;
            m_done = 1;
        end
        if (!pre_act && start) begin
            if (count == 0) begin
                m_done = 1;
            end else begin
                m_act  = 1;
                m_left = count;
                m_ptr  = base & 12'hFFC;
                m_ec   = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("busy", {31'd0, busy}, {31'd0, m_act});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("err_count", {24'd0, err_count}, m_ec);
        if (m_ov) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_addr", {20'd0, out_addr}, m_addr);
        end
    endtask

    task automatic entry(input logic [2:0] f, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] v);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = v;
    endtask

    task automatic rand_entry();
        int k;
        logic [31:0] v;
        k = $urandom_range(0, 3);
        case (k)
            0: v = $urandom_range(0, 4095) - 2048;
            1: v = $urandom_range(0, 1048575) - 524288;
            2: v = $urandom;
            default: v = imm_edges[$urandom_range(0, 9)];
        endcase
        entry(3'($urandom_range(0, 7)), 7'($urandom),
              3'($urandom), 7'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), v);
    endtask

    task automatic begin_batch(input logic [AW-1:0] b,
                               input logic [CW-1:0] c);
        start = 1; base = b; count = c;
        cyc();
        start = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (m_act && n < limit) begin
            cyc();
            n++;
        end
        if (m_act) begin
            checks++;
            errors++;
            $error("FAIL timeout observed=busy expected=idle");
            m_reset();
        end
    endtask

    task automatic rand_batch(input int n);
        begin_batch(AW'($urandom), CW'(n));
        while (m_act) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            count     = CW'($urandom_range(0, 5));
            rand_entry();
            cyc();
            if (checks > 60000) m_reset();
        end
        start = 0; in_valid = 0; out_ready = 1;
        cyc();
    endtask

    initial begin
        m_reset();
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", {20'd0, out_addr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;

        out_ready = 1;
        begin_batch(12'h100, 16'd3);
        in_valid = 1;
        entry(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        cyc();
        chk("addi", out_instr, 32'hFFF00093);
        chk("addi_addr", {20'd0, out_addr}, 32'h100);
        entry(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'd8);
        cyc();
        chk("sw", out_instr, 32'h0021A423);
        entry(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE);
        cyc();
        chk("beq", out_instr, 32'hFE000EE3);
        in_valid = 0;
        cyc();
        chk("done_3", {31'd0, done}, 32'd1);
        cyc();

        begin_batch(12'h000, 16'd0);
        chk("done_cnt0", {31'd0, done}, 32'd1);
        cyc();

        begin_batch(12'h040, 16'd1);
        in_valid = 1;
        entry(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        cyc();
        in_valid = 0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        chk("range_err", {31'd0, err}, 32'd1);
        chk("range_cnt", {24'd0, err_count}, 32'd1);
        chk("range_ov", {31'd0, out_valid}, 32'd0);
`else
        chk("range_word", out_instr, 32'h80000093);
`endif
        wait_idle(10);
        cyc();

        begin_batch(12'hFFF, 16'd2);
        in_valid = 1;
        entry(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345);
        cyc();
        chk("wrap_a0", {20'd0, out_addr}, 32'hFFC);
        entry(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFE);
        cyc();
        chk("wrap_a1", {20'd0, out_addr}, 32'h000);
        chk("jal", out_instr, 32'hFFDFF0EF);
        in_valid = 0;
        cyc();
        chk("wrap_done", {31'd0, done}, 32'd1);
        cyc();

        out_ready = 0;
        begin_batch(12'h200, 16'd4);
        in_valid = 1;
        entry(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        cyc();
        chk("sub", out_instr, 32'h402081B3);
        entry(3'd1, 7'h13, 3'd0, 7'd0, 5'd4, 5'd4, 5'd0, 32'd1);
        repeat (3) begin
            cyc();
            chk("bp_hold", out_instr, 32'h402081B3);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1;
        repeat (3) begin
            cyc();
            chk("bp_b2b", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 0;
        wait_idle(10);
        cyc();

        begin_batch(12'h000, 16'd260);
        in_valid = 1;
        entry(3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_idle(300);
        in_valid = 0;
        chk("err_sat", {24'd0, err_count}, 32'd255);
        cyc();

        begin_batch(12'h080, 16'd10);
        in_valid = 1;
        entry(3'd6, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cyc();
        entry(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cyc();
        rst_n = 0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ec", {24'd0, err_count}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
        m_reset();
        in_valid = 0;
        @(posedge clk);
        #1 rst_n = 1;

        for (int b = 0; b < 12; b++) begin
            rand_batch($urandom_range(1, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
